// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter.
// Merges ALU results and in-order load responses into one registered write port.
// A tag queue remembers the destination of every outstanding load, and a
// per-register pending scoreboard drives the decode-stage hazard signal and
// blocks write-after-write to registers that are still waiting on a load.
// Load responses always win the write port; the ALU waits until it is free.

module regfile_writeback #(
    parameter int LQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_issue,
    input  logic [4:0]  ld_rd,
    output logic        ld_issue_ready,
    input  logic        ld_resp_valid,
    input  logic [31:0] ld_resp_data,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        hazard,
    output logic        write_en,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        resp_err
);

    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(LQ_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LQ_DEPTH);

    logic [4:0]       tag_q [LQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Bit 0 exists only so every 5-bit register number indexes the vector
    // directly; it is held at zero because x0 can never be pending.
    logic [31:0]      pending;
    logic [31:0]      pending_nxt;

    logic             empty;
    logic             full;
    logic             push;
    logic             resp_active;
    logic [4:0]       head;

    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign head        = tag_q[rd_ptr];
    assign resp_active = ld_resp_valid && !empty;

    assign ld_issue_ready = !full && !((ld_rd != 5'd0) && pending[ld_rd]);
    assign push           = ld_issue && ld_issue_ready;

    assign alu_ready = alu_valid && !resp_active
                     && !((alu_rd != 5'd0) && pending[alu_rd]);

    assign hazard = ((rs1_addr != 5'd0) && pending[rs1_addr])
                  || ((rs2_addr != 5'd0) && pending[rs2_addr]);

    // Scoreboard update: retire the head tag, then mark a newly issued load.
    // The two can never name the same register because issue is blocked
    // while that register is still pending.
    always_comb begin
        pending_nxt = pending;
        if (resp_active) begin
            pending_nxt[head] = 1'b0;
        end
        if (push && (ld_rd != 5'd0)) begin
            pending_nxt[ld_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Tag storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            tag_q[wr_ptr] <= ld_rd;
        end
    end

    // Queue pointers, occupancy, scoreboard and sticky response error.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pending  <= '0;
            resp_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (resp_active) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, resp_active})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            pending <= pending_nxt;
            if (ld_resp_valid && empty) begin
                resp_err <= 1'b1;
            end
        end
    end

    // Registered write port; x0 destinations drop the data and leave the
    // address/data registers holding their previous values.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_en <= 1'b0;
            rd_addr  <= 5'd0;
            rd_data  <= 32'd0;
        end else if (resp_active) begin
            write_en <= (head != 5'd0);
            if (head != 5'd0) begin
                rd_addr <= head;
                rd_data <= ld_resp_data;
            end
        end else if (alu_ready) begin
            write_en <= (alu_rd != 5'd0);
            if (alu_rd != 5'd0) begin
                rd_addr <= alu_rd;
                rd_data <= alu_data;
            end
        end else begin
            write_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed stimulus pushes the expected register
// writes (destination, data, cycle) into a scoreboard queue, and a monitor
// pops and compares every write strobe the DUT produces.

module tb_regfile_writeback;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        ld_issue_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        hazard;
    logic        write_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        resp_err;

    regfile_writeback #(.LQ_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .ld_issue       (ld_issue),
        .ld_rd          (ld_rd),
        .ld_issue_ready (ld_issue_ready),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_data   (ld_resp_data),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .hazard         (hazard),
        .write_en       (write_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .resp_err       (resp_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expect a write in the cycle after the current inputs are accepted.
    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        wr_t e;
        e.rd   = rd;
        e.data = d;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Monitor: every strobe must match the oldest expected write, on time.
    always @(negedge clk) begin
        wr_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_write: no strobe for rd=%0d data=%0h due cycle %0d",
                     sb[0].rd, sb[0].data, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (write_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: rd_addr=%0d rd_data=%0h, expected no write (cycle %0d)",
                         rd_addr, rd_data, cyc);
            end else begin
                e = sb.pop_front();
                if (rd_addr !== e.rd || rd_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write: got rd=%0d data=%0h cycle %0d, expected rd=%0d data=%0h cycle %0d",
                             rd_addr, rd_data, cyc, e.rd, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_issue = 1'b0; ld_rd = '0;
        ld_resp_valid = 1'b0; ld_resp_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        step();
        step();
        chk("reset_write_en", write_en, 0);
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_resp_err", resp_err, 0);
        chk("reset_issue_ready", ld_issue_ready, 1);
        reset = 1'b0;
        step();

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        settle();
        chk("alu_ready_free", alu_ready, 1);
        expect_wr(5'd5, 32'hDEADBEEF);
        step();
        alu_valid = 1'b0;

        // Load with decode hazard
        ld_issue = 1'b1; ld_rd = 5'd7; rs1_addr = 5'd7;
        settle();
        chk("issue_ready_rd7", ld_issue_ready, 1);
        chk("hazard_before_issue", hazard, 0);
        step();
        ld_issue = 1'b0;
        chk("hazard_after_issue", hazard, 1);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h1234;
        expect_wr(5'd7, 32'h1234);
        settle();
        chk("hazard_during_resp", hazard, 1);
        step();
        ld_resp_valid = 1'b0;
        settle();
        chk("hazard_cleared", hazard, 0);
        rs1_addr = 5'd0;

        // Response beats ALU for the write port
        ld_issue = 1'b1; ld_rd = 5'd3;
        step();
        ld_issue = 1'b0;
        ld_resp_valid = 1'b1; ld_resp_data = 32'hAAAA0003;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        settle();
        chk("alu_blocked_by_resp", alu_ready, 0);
        expect_wr(5'd3, 32'hAAAA0003);
        step();
        ld_resp_valid = 1'b0;
        settle();
        chk("alu_ready_after_resp", alu_ready, 1);
        expect_wr(5'd6, 32'h66);
        step();
        alu_valid = 1'b0;

        // Fill the tag queue
        for (int i = 1; i <= 4; i++) begin
            ld_issue = 1'b1; ld_rd = 5'(i);
            settle();
            chk("issue_ready_fill", ld_issue_ready, 1);
            step();
        end
        ld_rd = 5'd5;
        settle();
        chk("issue_blocked_full", ld_issue_ready, 0);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h101;
        settle();
        chk("full_blocks_with_pop", ld_issue_ready, 0);
        expect_wr(5'd1, 32'h101);
        step();
        ld_resp_data = 32'h102;
        settle();
        chk("push_pop_same_cycle", ld_issue_ready, 1);
        expect_wr(5'd2, 32'h102);
        step();
        ld_issue = 1'b0;
        ld_resp_data = 32'h103;
        expect_wr(5'd3, 32'h103);
        step();
        ld_resp_data = 32'h104;
        expect_wr(5'd4, 32'h104);
        step();
        rs2_addr = 5'd5;
        settle();
        chk("hazard_rs2_rd5", hazard, 1);
        ld_resp_data = 32'h105;
        expect_wr(5'd5, 32'h105);
        step();
        ld_resp_valid = 1'b0;
        settle();
        chk("hazard_rs2_cleared", hazard, 0);
        rs2_addr = 5'd0;

        // WAW blocking on rd=9
        ld_issue = 1'b1; ld_rd = 5'd9;
        step();
        settle();
        chk("waw_issue_blocked", ld_issue_ready, 0);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h909;
        settle();
        chk("waw_alu_blocked", alu_ready, 0);
        step();
        ld_resp_valid = 1'b1; ld_resp_data = 32'h99;
        settle();
        chk("issue_blocked_retire_cycle", ld_issue_ready, 0);
        chk("alu_blocked_retire_cycle", alu_ready, 0);
        expect_wr(5'd9, 32'h99);
        step();
        ld_resp_valid = 1'b0;
        settle();
        chk("issue_ready_after_retire", ld_issue_ready, 1);
        chk("alu_ready_after_retire", alu_ready, 1);
        expect_wr(5'd9, 32'h909);
        step();
        ld_issue = 1'b0; alu_valid = 1'b0;
        ld_resp_valid = 1'b1; ld_resp_data = 32'h9999;
        expect_wr(5'd9, 32'h9999);
        step();
        ld_resp_valid = 1'b0;

        // Load to x0: tag consumed, no write, no hazard
        ld_issue = 1'b1; ld_rd = 5'd0;
        settle();
        chk("issue_ready_x0", ld_issue_ready, 1);
        step();
        ld_issue = 1'b0;
        settle();
        chk("hazard_x0", hazard, 0);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h0BAD0000;
        step();
        ld_resp_valid = 1'b0;
        step();
        chk("resp_err_after_x0", resp_err, 0);

        // Response with empty queue
        ld_resp_valid = 1'b1; ld_resp_data = 32'hE0E0E0E0;
        step();
        ld_resp_valid = 1'b0;
        chk("resp_err_set", resp_err, 1);
        step();
        step();
        chk("resp_err_sticky", resp_err, 1);

        // Reset mid-operation drops outstanding tags; ALU ignored during reset
        ld_issue = 1'b1; ld_rd = 5'd12; rs1_addr = 5'd12;
        step();
        ld_issue = 1'b0;
        chk("hazard_rd12", hazard, 1);
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hBAD;
        ld_issue = 1'b1; ld_rd = 5'd14;
        step();
        reset = 1'b0; alu_valid = 1'b0; ld_issue = 1'b0;
        chk("reset_mid_resp_err", resp_err, 0);
        chk("reset_mid_hazard", hazard, 0);
        chk("reset_mid_write_en", write_en, 0);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h12121212;
        step();
        ld_resp_valid = 1'b0;
        chk("resp_err_after_reset", resp_err, 1);
        rs1_addr = 5'd0;

        step();
        step();
        step();
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
